// File: rtl/vx_cache_bank_conflict_sched_pkg.sv
// Shared cache configuration: log2 helpers, bank-select offset,
// lane-index width and the scheduler state type.
package vx_cache_bank_conflict_sched_pkg;

   localparam int DEF_NUM_BANKS      = 4;
   localparam int DEF_NUM_REQUESTS   = 4;
   localparam int DEF_BANK_LINE_SIZE = 16;
   localparam int DEF_WORD_SIZE      = 4;
   localparam int DEF_WORD_ADDR_W    = 30;

   typedef enum logic {
      IDLE,
      DISPATCH
   } state_e;

   function automatic int log2c(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int lane_width(input int n);
      return (n > 1) ? log2c(n) : 1;
   endfunction

   function automatic int bank_ofs(input int line,
                                   input int word);
      return log2c(line / word);
   endfunction

endpackage

// File: rtl/vx_cache_bank_conflict_sched_if.sv
// Core request port and per-bank dispatch port of the
// bank conflict scheduler.
interface vx_cache_bank_conflict_sched_if
   import vx_cache_bank_conflict_sched_pkg::*;
#(
   parameter int NUM_BANKS       = DEF_NUM_BANKS,
   parameter int NUM_REQUESTS    = DEF_NUM_REQUESTS,
   parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_W
);
   localparam int LW = lane_width(NUM_REQUESTS);

   logic [NUM_REQUESTS-1:0]                      core_req_valid;
   logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0] core_req_addr;
   logic                                         core_req_ready;

   logic [NUM_BANKS-1:0]                      per_bank_valid;
   logic [NUM_BANKS-1:0][LW-1:0]              per_bank_lane;
   logic [NUM_BANKS-1:0][WORD_ADDR_WIDTH-1:0] per_bank_addr;
   logic [NUM_BANKS-1:0]                      per_bank_ready;

   modport master (
      output core_req_valid,
      output core_req_addr,
      input  core_req_ready,
      input  per_bank_valid,
      input  per_bank_lane,
      input  per_bank_addr,
      output per_bank_ready
   );

   modport slave (
      input  core_req_valid,
      input  core_req_addr,
      output core_req_ready,
      output per_bank_valid,
      output per_bank_lane,
      output per_bank_addr,
      input  per_bank_ready
   );

endinterface

// File: rtl/vx_cache_lane_pick.sv
// Lowest-index priority pick among pending lanes that
// target one bank.
module vx_cache_lane_pick #(
   parameter int N  = 4,
   parameter int LW = 2
) (
   input  logic [N-1:0]  pending,
   input  logic [N-1:0]  match,
   output logic          valid,
   output logic [LW-1:0] lane
);

   logic [N-1:0] req;

   assign req   = pending & match;
   assign valid = |req;

   // Scan downward so the lowest set lane wins.
   always_comb begin
      lane = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) lane = LW'(i);
      end
   end

endmodule

// File: rtl/vx_cache_bank_conflict_sched.sv
// Buffers one multi-lane core request and dispatches its lanes
// to their banks, serializing same-bank lanes lowest first.
module vx_cache_bank_conflict_sched
   import vx_cache_bank_conflict_sched_pkg::*;
#(
   parameter int NUM_BANKS       = DEF_NUM_BANKS,
   parameter int NUM_REQUESTS    = DEF_NUM_REQUESTS,
   parameter int BANK_LINE_SIZE  = DEF_BANK_LINE_SIZE,
   parameter int WORD_SIZE       = DEF_WORD_SIZE,
   parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_W
) (
   input  logic  clk,
   input  logic  reset,
   vx_cache_bank_conflict_sched_if.slave bus,
   output logic        busy,
   output logic [31:0] conflict_count
);

   localparam int NB  = NUM_BANKS;
   localparam int NR  = NUM_REQUESTS;
   localparam int AW  = WORD_ADDR_WIDTH;
   localparam int BW  = log2c(NUM_BANKS);
   localparam int LW  = lane_width(NUM_REQUESTS);
   localparam int OFS = bank_ofs(BANK_LINE_SIZE, WORD_SIZE);

   logic [NR-1:0]         pending;
   logic [NR-1:0][AW-1:0] addr_buf;

   logic [NB-1:0][NR-1:0] match;
   logic [NB-1:0]         pick_vld;
   logic [NB-1:0][LW-1:0] pick_idx;
   logic [NR-1:0]         sel_mask;
   logic [NR-1:0]         fired;

   state_e state;
   logic   last;
   logic   accept;
   logic   conflict;

   assign state = (|pending) ? DISPATCH : IDLE;

   always_comb begin
      match = '0;
      for (int b = 0; b < NB; b++) begin
         for (int i = 0; i < NR; i++) begin
            match[b][i] = (addr_buf[i][OFS +: BW] == BW'(b));
         end
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_pick
      vx_cache_lane_pick #(
         .N  (NR),
         .LW (LW)
      ) u_pick (
         .pending (pending),
         .match   (match[b]),
         .valid   (pick_vld[b]),
         .lane    (pick_idx[b])
      );
   end

   always_comb begin
      bus.per_bank_valid = '0;
      bus.per_bank_lane  = '0;
      bus.per_bank_addr  = '0;
      sel_mask           = '0;
      fired              = '0;
      for (int b = 0; b < NB; b++) begin
         bus.per_bank_valid[b] = pick_vld[b];
         for (int i = 0; i < NR; i++) begin
            if (pick_vld[b] && pick_idx[b] == LW'(i)) begin
               bus.per_bank_lane[b] = LW'(i);
               bus.per_bank_addr[b] = addr_buf[i];
               sel_mask[i]          = 1'b1;
               fired[i]             = bus.per_bank_ready[b];
            end
         end
      end
   end

   // Any pending lane left unselected is blocked by a lower lane
   // on the same bank; ready stalls never leave a lane unselected.
   assign conflict = (state == DISPATCH) &&
                     (|(pending & ~sel_mask));

   assign last = ((pending & ~fired) == '0);
   assign bus.core_req_ready = (state == IDLE) | last;
   assign accept = bus.core_req_ready & (|bus.core_req_valid);
   assign busy   = (state == DISPATCH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending        <= '0;
         addr_buf       <= '0;
         conflict_count <= '0;
      end else begin
         if (accept) begin
            pending  <= bus.core_req_valid;
            addr_buf <= bus.core_req_addr;
         end else begin
            pending  <= pending & ~fired;
         end
         if (conflict && conflict_count != '1) begin
            conflict_count <= conflict_count + 32'd1;
         end
      end
   end

endmodule

// File: doc/vx_cache_bank_conflict_sched.md
# vx_cache_bank_conflict_sched

Sequencing controller in front of the cache banks. It accepts one multi-lane core request, buffers it, and dispatches its lanes to their target banks over one or more cycles. When several lanes map to the same bank it serializes them, lowest lane index first, and holds back any lane whose bank is not ready. It sits between the core request port and the per-bank input queues, and counts bank-conflict stall cycles for performance reporting.

## Interface
- NUM_BANKS, default 4: banks; power of two, ≥2.
- NUM_REQUESTS, default 4: lanes per core request; power of two, ≥1.
- BANK_LINE_SIZE, default 16: bytes per bank line.
- WORD_SIZE, default 4: bytes per word.
- WORD_ADDR_WIDTH, default 30: word-address width.
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- core_req_valid, in, NUM_REQUESTS: per-lane valid.
- core_req_addr, in, NUM_REQUESTS×WORD_ADDR_WIDTH: per-lane word address.
- core_req_ready, out, 1: core request accepted this cycle.
- per_bank_valid, out, NUM_BANKS: bank b is presented a lane this cycle.
- per_bank_lane, out, NUM_BANKS×log2(NUM_REQUESTS) (min 1): lane index presented to bank b.
- per_bank_addr, out, NUM_BANKS×WORD_ADDR_WIDTH: buffered address of that lane.
- per_bank_ready, in, NUM_BANKS: bank b consumes its presented lane this cycle.
- busy, out, 1: request buffer holds pending lanes.
- conflict_count, out, 32: saturating count of bank-conflict stall cycles.

## Operation
- Bank index = word_addr[OFS +: log2(NUM_BANKS)], where OFS = log2(BANK_LINE_SIZE/WORD_SIZE).
- State: pending[NUM_REQUESTS] mask, addr_buf[NUM_REQUESTS], conflict_count. IDLE ⇔ pending == 0. DISPATCH ⇔ pending ≠ 0.
- Accept happens when core_req_ready & |core_req_valid. On accept:
  - pending ← core_req_valid.
  - addr_buf ← core_req_addr. Addresses of invalid lanes are don't-care.
- When core_req_valid == 0, nothing is captured, regardless of core_req_ready.
- Selection is combinational from registered state. For each bank b, sel_b = lowest-index pending lane whose bank index is b.
  - per_bank_valid[b] = sel_b exists.
  - per_bank_lane[b] = sel_b.
  - per_bank_addr[b] = addr_buf[sel_b].
  - With no lane for bank b, per_bank_lane[b] and per_bank_addr[b] are 0.
- A lane fires when per_bank_valid[b] & per_bank_ready[b]. Fired lanes are cleared from pending at the clock edge.
- Last-issue: last = (pending & ~fired) == 0.
- core_req_ready = IDLE | (DISPATCH & last).
  - A new request is accepted on the same edge that retires the last lanes.
  - On that edge, pending ← core_req_valid; the new request is not OR-merged with leftover lanes.
- busy = DISPATCH.
- conflict_count increments by 1 in each DISPATCH cycle where some pending lane is not selected because a lower-index lane holds its bank. It saturates at 2^32−1.
- Bank-ready stalls alone do not count.
- The outputs are valid/ready style: per_bank_valid, per_bank_lane and per_bank_addr stay stable while per_bank_ready is low and no reset occurs.

## Timing
- Reset, asynchronous and immediate, sets:
  - pending = 0, conflict_count = 0.
  - per_bank_valid = 0, per_bank_lane = 0, per_bank_addr = 0.
  - busy = 0, core_req_ready = 1.
- Reset during DISPATCH drops the buffered request; no lane is presented after reset asserts.
- Latency: a request accepted at edge T presents its first lanes in the cycle after T.
- Minimum occupancy is 1 cycle (no conflicts, all banks ready).
- With all banks ready, occupancy = max over banks of the number of lanes that map to that bank. Worst case is NUM_REQUESTS cycles.
- Back-to-back throughput: one request per occupancy cycle, with no idle bubble, via the last-issue accept.
- Combinational paths:
  - per_bank_ready → core_req_ready.
  - No path core_req_valid → per_bank_valid.

## Structure
- Shared cache config header/package: OFS and the bank-select range, log2 helpers, and the lane-index width.
- Sub-module vx_cache_lane_pick:
  - Combinational lowest-index priority pick.
  - Inputs: pending mask and a per-lane bank-match vector.
  - Outputs: a valid bit and the lane index.
  - Instantiated once per bank.
- The top level holds the pending/addr_buf/counter registers and the ready logic.

## Test plan
Configuration: 4 banks, 4 lanes, BANK_LINE_SIZE 16, WORD_SIZE 4; bank = addr[3:2].
- Reset mid-operation:
  - Stimulus: assert reset with pending = 0b0110.
  - Required response: all outputs 0 immediately, core_req_ready = 1, conflict_count = 0.
- No conflict:
  - Stimulus: valid 0b1111, addrs 0x0/0x4/0x8/0xC, all banks ready.
  - Required response: the next cycle shows per_bank_valid = 0b1111 with lanes 0,1,2,3 and core_req_ready = 1; busy is low after that edge.
- Full conflict:
  - Stimulus: valid 0b1111, addrs 0x0/0x10/0x20/0x30, all banks ready.
  - Required response: bank 0 presents lanes 0,1,2,3 on 4 consecutive cycles; core_req_ready is high only in the 4th; conflict_count = 3.
- Backpressure:
  - Stimulus: valid 0b0010, addr 0x4, per_bank_ready[1] low for 3 cycles.
  - Required response: per_bank_valid[1] = 1, lane 1, addr 0x4 held stable for 3 cycles; fires on the 4th; conflict_count unchanged.
- Back-to-back:
  - Stimulus: request A = valid 0b1010, addrs 0x4/0x14 (both bank 1), followed immediately by request B = valid 0b0001, addr 0x8.
  - Required response: A lane 1, then A lane 3 with B accepted on the same edge; B lane 0 is presented on bank 2 the next cycle with no bubble.
- Partial mask:
  - Stimulus: valid 0b0000 with core_req_ready high.
  - Required response: busy stays 0 and no bank is presented.
